// File: rtl/fpu_issue_if.sv
// Request/response handshake bundle between the FPU issue controller and its client.
interface fpu_issue_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_op;
    logic        req_rnd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_y;
    logic        rsp_error;
    logic        rsp_over_flow;

    modport master (
        output req_valid, req_a, req_b, req_op, req_rnd, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_error, rsp_over_flow
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_rnd, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_error, rsp_over_flow
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Sequencer for the handshake-less FPU core: holds operands, pulses start, captures after a fixed latency.
// Optional sticky error/overflow flags are enabled by defining FPU_ISSUE_STICKY_FLAGS_EN.
module fpu_issue_ctrl #(
    parameter int CAL_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    fpu_issue_if.slave  bus,
    output logic        cal_start,
    output logic [31:0] cal_a,
    output logic [31:0] cal_b,
    output logic [1:0]  cal_sel,
    output logic        cal_round_mode,
    input  logic [31:0] cal_y,
    input  logic        cal_error,
    input  logic        cal_over_flow,
    output logic        busy
`ifdef FPU_ISSUE_STICKY_FLAGS_EN
    ,
    input  logic        flag_clr,
    output logic        sticky_error,
    output logic        sticky_over_flow
`endif
);

    localparam int CNT_W = ($clog2(CAL_LATENCY + 1) > 3) ? $clog2(CAL_LATENCY + 1) : 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CAL_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    if (CAL_LATENCY < 4) begin : g_bad_latency
        $error("fpu_issue_ctrl: CAL_LATENCY must be 4 or more");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             capture;
    logic             req_ready;
    logic             rsp_valid;
    logic [31:0]      rsp_y_q;
    logic             rsp_error_q;
    logic             rsp_over_flow_q;

    // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        cal_start = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                cal_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == CNT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operands only change on accept, so the core sees them stable for the whole computation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cal_a          <= '0;
            cal_b          <= '0;
            cal_sel        <= '0;
            cal_round_mode <= 1'b0;
        end else if (accept) begin
            cal_a          <= bus.req_a;
            cal_b          <= bus.req_b;
            cal_sel        <= bus.req_op;
            cal_round_mode <= bus.req_rnd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == S_START) begin
            cnt <= CNT_LOAD;
        end else if (state == S_WAIT) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_y_q         <= '0;
            rsp_error_q     <= 1'b0;
            rsp_over_flow_q <= 1'b0;
        end else if (capture) begin
            rsp_y_q         <= cal_y;
            rsp_error_q     <= cal_error;
            rsp_over_flow_q <= cal_over_flow;
        end
    end

`ifdef FPU_ISSUE_STICKY_FLAGS_EN
    // A capture setting a flag takes priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_error     <= 1'b0;
            sticky_over_flow <= 1'b0;
        end else begin
            if (capture && cal_error) begin
                sticky_error <= 1'b1;
            end else if (flag_clr) begin
                sticky_error <= 1'b0;
            end
            if (capture && cal_over_flow) begin
                sticky_over_flow <= 1'b1;
            end else if (flag_clr) begin
                sticky_over_flow <= 1'b0;
            end
        end
    end
`endif

    assign bus.req_ready     = req_ready;
    assign bus.rsp_valid     = rsp_valid;
    assign bus.rsp_y         = rsp_y_q;
    assign bus.rsp_error     = rsp_error_q;
    assign bus.rsp_over_flow = rsp_over_flow_q;
    assign busy              = (state != S_IDLE);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a latency-accurate stand-in for the FPU core.
module tb_fpu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cal_start;
    logic [31:0] cal_a;
    logic [31:0] cal_b;
    logic [1:0]  cal_sel;
    logic        cal_round_mode;
    logic [31:0] cal_y;
    logic        cal_error;
    logic        cal_over_flow;
    logic        busy;
`ifdef FPU_ISSUE_STICKY_FLAGS_EN
    logic        flag_clr;
    logic        sticky_error;
    logic        sticky_over_flow;
`endif

    int n_checks;
    int n_errors;
    int start_cnt;
    int consec_cnt;
    logic prev_start;
    int core_cnt;

    fpu_issue_if u_bus ();

    fpu_issue_ctrl #(.CAL_LATENCY(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (u_bus),
        .cal_start      (cal_start),
        .cal_a          (cal_a),
        .cal_b          (cal_b),
        .cal_sel        (cal_sel),
        .cal_round_mode (cal_round_mode),
        .cal_y          (cal_y),
        .cal_error      (cal_error),
        .cal_over_flow  (cal_over_flow),
        .busy           (busy)
`ifdef FPU_ISSUE_STICKY_FLAGS_EN
        ,
        .flag_clr         (flag_clr),
        .sticky_error     (sticky_error),
        .sticky_over_flow (sticky_over_flow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Known vectors only; anything else yields a recognisable junk value.
    function automatic logic [33:0] core_result(input logic [31:0] a, input logic [31:0] b,
                                                input logic [1:0] sel);
        logic [33:0] r;
        r = {2'b00, 32'hBAD0_0000};
        if (sel == 2'b00 && a == 32'h3F80_0000 && b == 32'h4000_0000) r = {2'b00, 32'h4040_0000};
        if (sel == 2'b10 && a == 32'h4000_0000 && b == 32'h4040_0000) r = {2'b00, 32'h40C0_0000};
        if (sel == 2'b01 && a == 32'h7F80_0000 && b == 32'h7F80_0000) r = {2'b10, 32'h7FC0_0000};
        if (sel == 2'b11 && a == 32'h3F80_0000 && b == 32'h0000_0000) r = {2'b01, 32'h7F80_0000};
        return r;
    endfunction

    // Core model: junk while computing, result settles three edges after start is seen.
    always @(posedge clk) begin
        if (cal_start) begin
            core_cnt      <= 3;
            cal_y         <= 32'hDEAD_BEEF;
            cal_error     <= 1'b0;
            cal_over_flow <= 1'b0;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                {cal_error, cal_over_flow, cal_y} <= core_result(cal_a, cal_b, cal_sel);
            end
        end
    end

    always @(posedge clk) begin
        prev_start <= cal_start;
        if (cal_start) start_cnt <= start_cnt + 1;
        if (cal_start && prev_start) consec_cnt <= consec_cnt + 1;
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic rnd);
        int n;
        @(negedge clk);
        u_bus.req_valid = 1'b1;
        u_bus.req_a     = a;
        u_bus.req_b     = b;
        u_bus.req_op    = op;
        u_bus.req_rnd   = rnd;
        n = 0;
        while (!u_bus.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", {31'd0, u_bus.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        u_bus.req_valid = 1'b0;
        check("start_pulse", {31'd0, cal_start}, 32'd1);
        check("cal_a", cal_a, a);
        check("cal_b", cal_b, b);
        check("cal_sel", {30'd0, cal_sel}, {30'd0, op});
        check("cal_rnd", {31'd0, cal_round_mode}, {31'd0, rnd});
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!u_bus.rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_seen", {31'd0, u_bus.rsp_valid}, 32'd1);
    endtask

    task automatic take_rsp(input string tag, input logic [31:0] y, input logic err,
                            input logic ovf);
        check({tag, "_y"}, u_bus.rsp_y, y);
        check({tag, "_err"}, {31'd0, u_bus.rsp_error}, {31'd0, err});
        check({tag, "_ovf"}, {31'd0, u_bus.rsp_over_flow}, {31'd0, ovf});
        u_bus.rsp_ready = 1'b1;
        @(negedge clk);
        u_bus.rsp_ready = 1'b0;
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_rsp_valid"}, {31'd0, u_bus.rsp_valid}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic rnd, input logic [31:0] y,
                          input logic err, input logic ovf);
        int s0;
        int lat;
        s0 = start_cnt;
        send(a, b, op, rnd);
        wait_rsp(lat);
        check({tag, "_latency"}, lat, 32'd5);
        take_rsp(tag, y, err, ovf);
        check({tag, "_start_count"}, start_cnt - s0, 32'd1);
    endtask

    initial begin
        int s0;
        int lat;
        n_checks        = 0;
        n_errors        = 0;
        start_cnt       = 0;
        consec_cnt      = 0;
        prev_start      = 1'b0;
        core_cnt        = 0;
        cal_y           = 32'h0;
        cal_error       = 1'b0;
        cal_over_flow   = 1'b0;
        rst_n           = 1'b0;
        u_bus.req_valid = 1'b0;
        u_bus.req_a     = 32'h0;
        u_bus.req_b     = 32'h0;
        u_bus.req_op    = 2'b00;
        u_bus.req_rnd   = 1'b0;
        u_bus.rsp_ready = 1'b0;
`ifdef FPU_ISSUE_STICKY_FLAGS_EN
        flag_clr        = 1'b0;
`endif
        #12;
        check("rst_req_ready", {31'd0, u_bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, u_bus.rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cal_start", {31'd0, cal_start}, 32'd0);
        check("rst_rsp_y", u_bus.rsp_y, 32'd0);
        check("rst_cal_a", cal_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add", 32'h3F80_0000, 32'h4000_0000, 2'b00, 1'b0, 32'h4040_0000, 1'b0, 1'b0);
        run_op("mul", 32'h4000_0000, 32'h4040_0000, 2'b10, 1'b1, 32'h40C0_0000, 1'b0, 1'b0);
        run_op("inf_sub", 32'h7F80_0000, 32'h7F80_0000, 2'b01, 1'b0, 32'h7FC0_0000, 1'b1, 1'b0);
        run_op("div0", 32'h3F80_0000, 32'h0000_0000, 2'b11, 1'b0, 32'h7F80_0000, 1'b0, 1'b1);

        // Backpressure with a second request waiting.
        s0 = start_cnt;
        send(32'h4000_0000, 32'h4040_0000, 2'b10, 1'b0);
        wait_rsp(lat);
        check("bp_latency", lat, 32'd5);
        u_bus.req_valid = 1'b1;
        u_bus.req_a     = 32'h3F80_0000;
        u_bus.req_b     = 32'h0000_0000;
        u_bus.req_op    = 2'b11;
        u_bus.req_rnd   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", {31'd0, u_bus.rsp_valid}, 32'd1);
            check("bp_rsp_y", u_bus.rsp_y, 32'h40C0_0000);
            check("bp_req_ready", {31'd0, u_bus.req_ready}, 32'd0);
        end
        check("bp_start_count", start_cnt - s0, 32'd1);
        u_bus.rsp_ready = 1'b1;
        @(negedge clk);
        u_bus.rsp_ready = 1'b0;
        check("bp_idle_req_ready", {31'd0, u_bus.req_ready}, 32'd1);
        check("bp_idle_rsp_valid", {31'd0, u_bus.rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        u_bus.req_valid = 1'b0;
        check("bp2_start", {31'd0, cal_start}, 32'd1);
        check("bp2_cal_a", cal_a, 32'h3F80_0000);
        wait_rsp(lat);
        check("bp2_latency", lat, 32'd5);
        take_rsp("bp2", 32'h7F80_0000, 1'b0, 1'b1);
        check("bp_total_starts", start_cnt - s0, 32'd2);

        // Reset in the second WAIT cycle discards the operation.
        send(32'h3F80_0000, 32'h4000_0000, 2'b00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", {31'd0, u_bus.rsp_valid}, 32'd0);
        check("mid_rst_req_ready", {31'd0, u_bus.req_ready}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_cal_a", cal_a, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_rsp_valid", {31'd0, u_bus.rsp_valid}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        run_op("add_post_rst", 32'h3F80_0000, 32'h4000_0000, 2'b00, 1'b0, 32'h4040_0000, 1'b0, 1'b0);

`ifdef FPU_ISSUE_STICKY_FLAGS_EN
        @(negedge clk);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        check("sticky_clr0_ovf", {31'd0, sticky_over_flow}, 32'd0);
        run_op("st_div0", 32'h3F80_0000, 32'h0000_0000, 2'b11, 1'b0, 32'h7F80_0000, 1'b0, 1'b1);
        check("sticky_ovf_set", {31'd0, sticky_over_flow}, 32'd1);
        run_op("st_add", 32'h3F80_0000, 32'h4000_0000, 2'b00, 1'b0, 32'h4040_0000, 1'b0, 1'b0);
        check("sticky_ovf_hold", {31'd0, sticky_over_flow}, 32'd1);
        @(negedge clk);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        check("sticky_ovf_clr", {31'd0, sticky_over_flow}, 32'd0);
        check("sticky_err_clr", {31'd0, sticky_error}, 32'd0);
        send(32'h7F80_0000, 32'h7F80_0000, 2'b01, 1'b0);
        repeat (4) @(negedge clk);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        check("sticky_set_wins_valid", {31'd0, u_bus.rsp_valid}, 32'd1);
        check("sticky_set_wins_err", {31'd0, sticky_error}, 32'd1);
        take_rsp("st_inf_sub", 32'h7FC0_0000, 1'b1, 1'b0);
`endif

        check("no_consecutive_start", consec_cnt, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Upstream sequencer for the FPU calculation core; the core's inputs are A, B, sel, round_mode and start, and its outputs are Y, error and over_flow.
- Accepts one operation at a time over a valid/ready request port, registers the operands and holds them stable, and pulses the core's start for exactly one cycle.
- Waits the core's fixed latency, captures the result and flags, then presents them on a valid/ready response port.
- Exists because the core has no handshake, no reset, and needs its operands held stable for the whole computation.

Parameters:
- CAL_LATENCY, default 4: number of WAIT cycles between the start cycle and result capture. Legal values are 4 and above; smaller values are illegal.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  block can accept a request
- req_a  in  32  operand A (IEEE-754 single)
- req_b  in  32  operand B
- req_op  in  2  00 add, 01 sub, 10 mul, 11 div
- req_rnd  in  1  round mode
- cal_start  out  1  core start pulse
- cal_a  out  32  core A
- cal_b  out  32  core B
- cal_sel  out  2  core sel
- cal_round_mode  out  1  core round_mode
- cal_y  in  32  core Y
- cal_error  in  1  core error
- cal_over_flow  in  1  core over_flow
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts the response
- rsp_y  out  32  result
- rsp_error  out  1  NaN/invalid flag
- rsp_over_flow  out  1  overflow flag
- busy  out  1  state is not IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs and registers 0, except req_ready=1 as decoded from IDLE.
- The FSM has four states: IDLE, START, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch req_a/b/op/rnd into the operand registers; next state START.
- START:
  - cal_start=1 for this cycle only.
  - Load the 3-bit-min counter cnt with CAL_LATENCY; next state WAIT.
- WAIT:
  - cnt decrements each cycle.
  - When cnt==1: capture cal_y, cal_error and cal_over_flow into the rsp registers; next state RESP.
- RESP:
  - rsp_valid=1.
  - On rsp_ready: next state IDLE.
  - rsp_* hold stable while rsp_ready is low.
- cal_a/cal_b/cal_sel/cal_round_mode are driven directly from the operand registers. They change only on a request accept, so they are stable from START through capture and beyond.
- req_ready=1 only in IDLE; there is no back-to-back issue. Throughput is one operation per CAL_LATENCY+3 cycles when rsp_ready is held high.
- Latency with default CAL_LATENCY: accept edge E0, start cycle E0→E1, capture at E5, rsp_valid high from E5 (5 cycles after accept).
- The core's early-exit results (NaN, zero, infinity) appear before capture and stay held, so the same fixed capture point is correct for them.
- Requests presented outside IDLE are ignored; the upstream holds them under the valid/ready rules.
- Reset mid-operation: the block returns to IDLE immediately and any in-flight result is discarded. The core needs no reset: the next cal_start reinitialises it.
- cal_start is never asserted in two consecutive cycles.
- busy = state != IDLE.

Optional Feature:
- Macro: FPU_ISSUE_STICKY_FLAGS_EN.
- When defined, the block adds:
  - Input flag_clr (1 bit).
  - Outputs sticky_error and sticky_over_flow (1 bit each, reset 0).
- Sticky flags are set at the capture edge when the captured flag is 1.
- flag_clr=1 clears both sticky flags on the next edge; if set and clear coincide, set wins.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Add: req_a=0x3F800000, req_b=0x40000000, op=00, rnd=0 → rsp_y=0x40400000, error=0, over_flow=0; rsp_valid rises exactly 5 cycles after the accept edge; cal_start high for exactly 1 cycle.
- Mul: 0x40000000 × 0x40400000, op=10 → rsp_y=0x40C00000, flags 0.
- INF−INF: 0x7F800000, 0x7F800000, op=01 → rsp_y=0x7FC00000, rsp_error=1. Div by zero: 0x3F800000 / 0x00000000, op=11 → rsp_y=0x7F800000, rsp_over_flow=1.
- Backpressure: rsp_ready=0 for 10 cycles with a second request pending → rsp_* stable, req_ready=0 and no extra cal_start; after rsp_ready=1, IDLE, then the second op is accepted.
- Reset: assert rst_n=0 in the second WAIT cycle → rsp_valid=0, state IDLE, req_ready=1. The next add op (1.0+2.0) still returns 0x40400000.
- With FPU_ISSUE_STICKY_FLAGS_EN: the div-by-zero op sets sticky_over_flow=1. A following 1.0+2.0 leaves it at 1; flag_clr pulse → 0; flag_clr coinciding with an INF−INF capture → sticky_error=1.
